// File: rtl/usb_cdc_pkg.sv
// Shared types and constants for the toggle-handshake CDC sender.
// Used by usb_cdc_sender and usb_cdc_bitsync.
package usb_cdc_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/usb_cdc_bitsync.sv
// Single-bit flop-chain synchronizer with asynchronous reset to 0.
// Chains shorter than SYNC_STAGES_MIN are widened to the minimum.
module usb_cdc_bitsync
  import usb_cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset1_async,
  input  logic d,
  output logic q
);

  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [N-1:0] chain;

  always_ff @(posedge clock or posedge reset1_async) begin
    if (reset1_async) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/usb_cdc_sender.sv
// Source side of a toggle-handshake clock-domain crossing.
// Optional ack timeout detection is built when USB_CDCTX_TIMEOUT_EN is defined.
module usb_cdc_sender
  import usb_cdc_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] DATA_ONRST     = '0,
  parameter int                    SYNC_STAGES    = 2,
  parameter int                    TIMEOUT_CYCLES = 1023
) (
  input  logic                  clock,
  input  logic                  reset1_async,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_ack_async,
  output logic                  busy,
  output logic                  timeout_err
);

  state_t state;
  logic   ack_sync;
  logic   handshake;

  usb_cdc_bitsync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clock        (clock),
    .reset1_async (reset1_async),
    .d            (xfer_ack_async),
    .q            (ack_sync)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state == WAIT_ACK);
  assign handshake = in_valid && in_ready;

  // A word stays frozen on xfer_data until the returned toggle matches xfer_req;
  // mismatching ack toggles seen in IDLE are ignored.
  always_ff @(posedge clock or posedge reset1_async) begin
    if (reset1_async) begin
      state     <= IDLE;
      xfer_req  <= 1'b0;
      xfer_data <= DATA_ONRST;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            xfer_data <= in_data;
            xfer_req  <= ~xfer_req;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_sync == xfer_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USB_CDCTX_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_flag;

  // Counter saturates at the limit; the flag is sticky until reset.
  always_ff @(posedge clock or posedge reset1_async) begin
    if (reset1_async) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (handshake) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_ACK && tmo_cnt != CNT_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == WAIT_ACK && tmo_cnt == CNT_MAX) begin
        tmo_flag <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_flag;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_cdc_sender.sv
// Directed self-checking bench for usb_cdc_sender (SYNC_STAGES=2, TIMEOUT_CYCLES=15).
// The bench plays the destination side by toggling the ack input by hand.
module tb_usb_cdc_sender;

  logic       clock = 1'b0;
  logic       reset1_async;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       xfer_req;
  logic [7:0] xfer_data;
  logic       xfer_ack_async;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  logic exp_req = 1'b0;

  usb_cdc_sender #(
    .DATA_WIDTH     (8),
    .DATA_ONRST     (8'h00),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clock          (clock),
    .reset1_async   (reset1_async),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: in_ready=%b after %0d clocks, required 1", name, in_ready, n);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    exp_req  = ~exp_req;
  endtask

  task automatic test_reset();
    reset1_async   = 1'b1;
    in_valid       = 1'b0;
    in_data        = 8'h5A;
    xfer_ack_async = 1'b0;
    tick();
    tick();
    checks += 5;
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (xfer_req !== 1'b0)    begin errors++; $display("FAIL reset_req: got %b need 0", xfer_req); end
    if (xfer_data !== 8'h00)  begin errors++; $display("FAIL reset_data: got %h need 00", xfer_data); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b need 0", timeout_err); end
    reset1_async = 1'b0;
    exp_req      = 1'b0;
    tick();
  endtask

  task automatic test_single();
    send_word(8'hA5);
    checks += 4;
    if (xfer_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h need a5", xfer_data); end
    if (xfer_req !== 1'b1)   begin errors++; $display("FAIL single_req: got %b need 1", xfer_req); end
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL single_ready_low: got %b need 0", in_ready); end
    if (busy !== 1'b1)       begin errors++; $display("FAIL single_busy: got %b need 1", busy); end
    xfer_ack_async = ~xfer_ack_async;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (in_ready !== (k == 3)) begin
        errors++;
        $display("FAIL single_latency: clock %0d in_ready=%b need %b", k, in_ready, (k == 3));
      end
    end
    checks++;
    if (xfer_data !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h need a5", xfer_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    words[0] = 8'h11;
    words[1] = 8'h22;
    in_valid = 1'b1;
    in_data  = words[0];
    for (int w = 0; w < 2; w++) begin
      // in_ready is high here, so the next edge captures the offered word
      tick();
      exp_req = ~exp_req;
      if (w == 0) in_data = words[1];
      else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      for (int d = 0; d < 10; d++) begin
        checks++;
        if (xfer_data !== words[w] || xfer_req !== exp_req || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold: word %0d clk %0d data=%h req=%b rdy=%b need %h %b 0",
                   w, d, xfer_data, xfer_req, in_ready, words[w], exp_req);
        end
        tick();
      end
      xfer_ack_async = ~xfer_ack_async;
      wait_idle("b2b_complete");
    end
  endtask

  task automatic test_reset_mid();
    send_word(8'h33);
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b need 1", busy); end
    #2;
    reset1_async   = 1'b1;
    xfer_ack_async = 1'b0;
    #1;
    checks += 4;
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL mid_ready: got %b need 1", in_ready); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL mid_busy_clr: got %b need 0", busy); end
    if (xfer_req !== 1'b0)   begin errors++; $display("FAIL mid_req: got %b need 0", xfer_req); end
    if (xfer_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h need 00", xfer_data); end
    tick();
    reset1_async = 1'b0;
    exp_req      = 1'b0;
    tick();
    send_word(8'h44);
    checks++;
    if (xfer_data !== 8'h44 || xfer_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_resend: data=%h req=%b need 44 1", xfer_data, xfer_req);
    end
    xfer_ack_async = ~xfer_ack_async;
    wait_idle("mid_complete");
  endtask

  task automatic test_spurious();
    xfer_ack_async = ~xfer_ack_async;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || xfer_req !== exp_req) begin
        errors++;
        $display("FAIL spurious: clk %0d rdy=%b busy=%b req=%b need 1 0 %b",
                 k, in_ready, busy, xfer_req, exp_req);
      end
    end
    xfer_ack_async = ~xfer_ack_async;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    send_word(8'h55);
    repeat (12) tick();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b need 0", timeout_err); end
    repeat (8) tick();
`ifdef USB_CDCTX_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b need 1", timeout_err); end
`else
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_off: got %b need 0", timeout_err); end
`endif
    checks++;
    if (busy !== 1'b1 || xfer_data !== 8'h55) begin
      errors++;
      $display("FAIL tmo_wait: busy=%b data=%h need 1 55", busy, xfer_data);
    end
    xfer_ack_async = ~xfer_ack_async;
    wait_idle("tmo_late_ack");
    checks++;
`ifdef USB_CDCTX_TIMEOUT_EN
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b need 1", timeout_err); end
`else
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_off_after: got %b need 0", timeout_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
